// File: rtl/i2c_apb_pkg.sv
// rtl/i2c_apb_pkg.sv - shared register map, field indices and FSM encoding for the I2C APB CSR block
// Purpose: constants and types imported by i2c_master_apb_csr.
// Contents: register word offsets (paddr[4:2]), CMD/STATUS bit indices,
//           command entry width, FSM state type.
package i2c_apb_pkg;

  // Register select values for paddr[4:2]
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_CMD    = 3'd1;
  localparam logic [2:0] REG_RDATA  = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;

  // CTRL bits
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;

  // CMD entry layout: [7:0] wdata, [23:8] addr, [24] bit_ctrl, [25] rh_wl
  localparam int CMD_W        = 26;
  localparam int CMD_ADDR_LSB = 8;
  localparam int CMD_BIT_CTRL = 24;
  localparam int CMD_RH_WL    = 25;

  // STATUS bits
  localparam int ST_BUSY      = 0;
  localparam int ST_CMD_FULL  = 1;
  localparam int ST_CMD_EMPTY = 2;
  localparam int ST_RD_EMPTY  = 3;
  localparam int ST_RD_FULL   = 4;
  localparam int ST_NACK      = 5;
  localparam int ST_RD_OVF    = 6;
  localparam int ST_TIMEOUT   = 7;
  localparam int ST_CNT_LSB   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/i2c_sync_fifo.sv
// rtl/i2c_sync_fifo.sv - synchronous FIFO with push/pop/flush, full/empty/count
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata (head, show-ahead),
//        flush (empties; wins over push/pop), full, empty, count.
// A push while full is accepted only if a pop happens in the same cycle.
module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wptr == rptr);
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/i2c_master_apb_csr.sv
// rtl/i2c_master_apb_csr.sv - APB3 register file and command sequencer for an I2C byte master
// Purpose: software queues byte commands via CMD, the sequencer issues them one at a
//          time to the master, collects read bytes into RDATA and keeps sticky flags.
// Ports: apb_clk/apb_rstn; APB slave (psel/penable/pwrite/paddr/pwdata/prot/pstrb ->
//        pready/prdata/slverr); master command out (wvalid pulse, bit_ctrl, rh_wl,
//        addr, wdata); master response in (rdata/rvalid, done, ack = NACK, busy).
module i2c_master_apb_csr
  import i2c_apb_pkg::*;
#(
  parameter int APB_ABIT     = 32,
  parameter int APB_DBIT     = 32,
  parameter int CMD_DEPTH    = 4,
  parameter int RD_DEPTH     = 4,
  parameter int TIMEOUT_CYC  = 200000,
  parameter int HALT_ON_NACK = 1
) (
  input  logic                apb_clk,
  input  logic                apb_rstn,
  input  logic                i_apb_psel,
  input  logic                i_apb_penable,
  input  logic                i_apb_pwrite,
  input  logic [APB_ABIT-1:0] i_apb_paddr,
  input  logic [APB_DBIT-1:0] i_apb_pwdata,
  input  logic [2:0]          i_apb_prot,
  input  logic [3:0]          i_apb_pstrb,
  output logic                o_apb_pready,
  output logic [APB_DBIT-1:0] o_apb_prdata,
  output logic                o_apb_slverr,
  output logic                o_i2c_wvalid,
  output logic                o_cmd_bit_ctrl,
  output logic                o_cmd_rh_wl,
  output logic [15:0]         o_i2c_addr,
  output logic [7:0]          o_i2c_wdata,
  input  logic [7:0]          i_i2c_rdata,
  input  logic                i_i2c_rvalid,
  input  logic                i_i2c_done,
  input  logic                i_i2c_ack,
  input  logic                i_i2c_busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = $clog2(CMD_DEPTH) + 1;
  localparam int RW = $clog2(RD_DEPTH) + 1;

  state_t          state;
  logic [TW-1:0]   cnt;
  logic            enable, nack, rd_ovf, timeout;

  logic            access;
  logic [2:0]      reg_sel;
  logic            cmd_push, rd_pop, flush, ctrl_we, issue_go, rd_push, busy;
  logic [2:0]      w1c;
  logic [31:0]     status_word;

  logic [CMD_W-1:0] cmd_head;
  logic             cmd_full, cmd_empty;
  logic [CW-1:0]    cmd_count;
  logic [7:0]       rd_head;
  logic             rd_full, rd_empty;
  logic [RW-1:0]    rd_count_unused;
  logic             unused_ok;

  assign unused_ok = ^{i_apb_prot, i_apb_pstrb, i_i2c_busy, i_apb_paddr[APB_ABIT-1:5],
                       i_apb_paddr[1:0], i_apb_pwdata[APB_DBIT-1:CMD_W], rd_count_unused};

  assign o_apb_pready = 1'b1;
  assign access       = i_apb_psel & i_apb_penable;
  assign reg_sel      = i_apb_paddr[4:2];
  assign busy         = (state != S_IDLE) | ~cmd_empty;
  assign issue_go     = (state == S_IDLE) & enable & ~cmd_empty & ~((HALT_ON_NACK != 0) & nack);
  assign rd_push      = (state == S_WAIT) & i_i2c_rvalid & o_cmd_rh_wl;

  i2c_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(apb_clk), .rst_n(apb_rstn), .push(cmd_push), .wdata(i_apb_pwdata[CMD_W-1:0]),
    .pop(issue_go), .flush(flush), .rdata(cmd_head), .full(cmd_full),
    .empty(cmd_empty), .count(cmd_count)
  );

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk(apb_clk), .rst_n(apb_rstn), .push(rd_push), .wdata(i_i2c_rdata),
    .pop(rd_pop), .flush(flush), .rdata(rd_head), .full(rd_full),
    .empty(rd_empty), .count(rd_count_unused)
  );

  always_comb begin
    status_word               = '0;
    status_word[ST_BUSY]      = busy;
    status_word[ST_CMD_FULL]  = cmd_full;
    status_word[ST_CMD_EMPTY] = cmd_empty;
    status_word[ST_RD_EMPTY]  = rd_empty;
    status_word[ST_RD_FULL]   = rd_full;
    status_word[ST_NACK]      = nack;
    status_word[ST_RD_OVF]    = rd_ovf;
    status_word[ST_TIMEOUT]   = timeout;
    status_word[ST_CNT_LSB +: 8] = 8'(cmd_count);
  end

  // Register decode; every side effect is qualified by the access cycle.
  always_comb begin
    o_apb_prdata = '0;
    o_apb_slverr = 1'b0;
    cmd_push     = 1'b0;
    rd_pop       = 1'b0;
    flush        = 1'b0;
    ctrl_we      = 1'b0;
    w1c          = '0;
    if (access) begin
      case (reg_sel)
        REG_CTRL: begin
          if (i_apb_pwrite) begin
            ctrl_we = 1'b1;
            flush   = i_apb_pwdata[CTRL_FLUSH];
          end else begin
            o_apb_prdata = APB_DBIT'(enable);
          end
        end
        REG_CMD: begin
          // Full is judged before any same-cycle issue pop.
          if (i_apb_pwrite && !cmd_full) cmd_push = 1'b1;
          else o_apb_slverr = 1'b1;
        end
        REG_RDATA: begin
          if (i_apb_pwrite) begin
            o_apb_slverr = 1'b1;
          end else if (!rd_empty) begin
            o_apb_prdata = APB_DBIT'({1'b1, rd_head});
            rd_pop       = 1'b1;
          end
        end
        REG_STATUS: begin
          if (i_apb_pwrite) w1c = i_apb_pwdata[ST_TIMEOUT:ST_NACK];
          else o_apb_prdata = status_word;
        end
        default: o_apb_slverr = 1'b1;
      endcase
    end
  end

  // Control bit and sticky flags; a set event outranks a same-cycle W1C.
  always_ff @(posedge apb_clk or negedge apb_rstn) begin
    if (!apb_rstn) begin
      enable  <= 1'b0;
      nack    <= 1'b0;
      rd_ovf  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (ctrl_we) enable <= i_apb_pwdata[CTRL_ENABLE];
      nack    <= (nack & ~w1c[0]) | ((state == S_WAIT) & i_i2c_done & i_i2c_ack);
      rd_ovf  <= (rd_ovf & ~w1c[1]) | (rd_push & rd_full & ~rd_pop);
      timeout <= (timeout & ~w1c[2]) |
                 ((state == S_WAIT) & ~i_i2c_done & (cnt == TW'(TIMEOUT_CYC - 1)));
    end
  end

  // Command fields are latched on entry to ISSUE and held until the next issue.
  always_ff @(posedge apb_clk or negedge apb_rstn) begin
    if (!apb_rstn) begin
      state          <= S_IDLE;
      cnt            <= '0;
      o_i2c_wvalid   <= 1'b0;
      o_cmd_bit_ctrl <= 1'b0;
      o_cmd_rh_wl    <= 1'b0;
      o_i2c_addr     <= '0;
      o_i2c_wdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue_go) begin
            state          <= S_ISSUE;
            o_i2c_wvalid   <= 1'b1;
            o_i2c_wdata    <= cmd_head[7:0];
            o_i2c_addr     <= cmd_head[CMD_ADDR_LSB +: 16];
            o_cmd_bit_ctrl <= cmd_head[CMD_BIT_CTRL];
            o_cmd_rh_wl    <= cmd_head[CMD_RH_WL];
          end
        end
        S_ISSUE: begin
          o_i2c_wvalid <= 1'b0;
          cnt          <= '0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (i_i2c_done || cnt == TW'(TIMEOUT_CYC - 1)) state <= S_IDLE;
          else cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_apb_csr.sv
// tb/tb_i2c_master_apb_csr.sv - directed scoreboard testbench for i2c_master_apb_csr
module tb_i2c_master_apb_csr;

  localparam int TO_CYC = 300;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        pready, slverr, wvalid, bit_ctrl, rh_wl;
  logic [31:0] prdata;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_wdata;
  logic [7:0]  i2c_rdata = '0;
  logic        i2c_rvalid = 1'b0, i2c_done = 1'b0, i2c_ack = 1'b0;

  int passes = 0;
  int total = 0;
  int wv_count = 0;
  logic [25:0] cmd_q[$];
  logic [7:0]  rd_q[$];

  always #5 clk = ~clk;

  i2c_master_apb_csr #(.TIMEOUT_CYC(TO_CYC)) dut (
    .apb_clk(clk), .apb_rstn(rstn),
    .i_apb_psel(psel), .i_apb_penable(penable), .i_apb_pwrite(pwrite),
    .i_apb_paddr(paddr), .i_apb_pwdata(pwdata), .i_apb_prot(3'b000), .i_apb_pstrb(4'hF),
    .o_apb_pready(pready), .o_apb_prdata(prdata), .o_apb_slverr(slverr),
    .o_i2c_wvalid(wvalid), .o_cmd_bit_ctrl(bit_ctrl), .o_cmd_rh_wl(rh_wl),
    .o_i2c_addr(i2c_addr), .o_i2c_wdata(i2c_wdata),
    .i_i2c_rdata(i2c_rdata), .i_i2c_rvalid(i2c_rvalid), .i_i2c_done(i2c_done),
    .i_i2c_ack(i2c_ack), .i_i2c_busy(1'b0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Issue monitor: each wvalid pulse must match the oldest queued command.
  always @(negedge clk) begin
    if (wvalid === 1'b1) begin
      logic [25:0] e;
      wv_count++;
      if (cmd_q.size() == 0) begin
        check("unexpected_issue", 32'd1, 32'd0);
      end else begin
        e = cmd_q.pop_front();
        check("issue_addr", 32'(i2c_addr), 32'(e[23:8]));
        check("issue_wdata", 32'(i2c_wdata), 32'(e[7:0]));
        check("issue_bit_ctrl", 32'(bit_ctrl), 32'(e[24]));
        check("issue_rh_wl", 32'(rh_wl), 32'(e[25]));
      end
    end
  end

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 err = slverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 d = prdata; err = slverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] c);
    logic err;
    cmd_q.push_back(c[25:0]);
    apb_write(32'h04, c, err);
    check("cmd_write_slverr", 32'(err), 32'd0);
  endtask

  task automatic wait_wvalid();
    logic seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wvalid === 1'b1) begin seen = 1'b1; break; end
    end
    check("wvalid_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("wvalid_one_cycle", 32'(wvalid), 32'd0);
  endtask

  task automatic master_resp(input int dly, input logic rd, input logic [7:0] b, input logic a);
    repeat (dly) @(posedge clk);
    #1;
    if (rd) begin
      i2c_rvalid = 1'b1; i2c_rdata = b;
      if (rd_q.size() < 4) rd_q.push_back(b);
      @(posedge clk); #1;
      i2c_rvalid = 1'b0;
    end
    i2c_done = 1'b1; i2c_ack = a;
    @(posedge clk); #1;
    i2c_done = 1'b0; i2c_ack = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    logic err;
    apb_read(32'h0C, d, err);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic err;
    int n;
    int wv0;

    // Reset state
    #12;
    check("rst_pready", 32'(pready), 32'd1);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_outs", {8'(bit_ctrl), 8'(rh_wl), i2c_addr}, 32'd0);
    check("rst_wdata", 32'(i2c_wdata), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    @(negedge clk) rstn = 1'b1;
    check_status("rst_status", 32'h0000_000C);

    // 8-bit write command
    apb_write(32'h00, 32'h1, err);
    push_cmd(32'h0000_12AB);
    wait_wvalid();
    master_resp(50, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    check_status("write_done_status", 32'h0000_000C);
    check("addr_held", 32'(i2c_addr), 32'h0012);

    // 16-bit read command
    push_cmd(32'h0300_3400);
    wait_wvalid();
    master_resp(5, 1'b1, 8'h5A, 1'b0);
    apb_read(32'h08, d, err);
    check("rdata_first", d, {23'd0, 1'b1, rd_q.pop_front()});
    apb_read(32'h08, d, err);
    check("rdata_empty", d, 32'd0);

    // Command FIFO overflow with enable = 0
    apb_write(32'h00, 32'h0, err);
    wv0 = wv_count;
    for (int i = 0; i < 5; i++) begin
      apb_write(32'h04, 32'h0000_0100 + 32'(i), err);
      check("cmd_fill_slverr", 32'(err), (i == 4) ? 32'd1 : 32'd0);
    end
    check_status("cmd_full_status", 32'h0000_040B);
    check("no_issue_disabled", 32'(wv_count), 32'(wv0));
    apb_write(32'h00, 32'h2, err);
    check_status("flush_status", 32'h0000_000C);

    // NACK halts further issue until W1C
    push_cmd(32'h0000_5501);
    push_cmd(32'h0000_6602);
    apb_write(32'h00, 32'h1, err);
    wait_wvalid();
    wv0 = wv_count;
    master_resp(10, 1'b0, 8'h00, 1'b1);
    repeat (20) @(posedge clk);
    check("halt_on_nack", 32'(wv_count), 32'(wv0));
    check_status("nack_status", 32'h0000_0129);
    apb_write(32'h0C, 32'h20, err);
    wait_wvalid();
    master_resp(10, 1'b0, 8'h00, 1'b0);
    check_status("nack_cleared_status", 32'h0000_000C);

    // Timeout: hold a STATUS read access and count cycles until the flag appears
    push_cmd(32'h0000_7703);
    wait_wvalid();
    paddr = 32'h0C; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
    n = 0;
    for (int i = 0; i < TO_CYC + 20; i++) begin
      @(negedge clk);
      n++;
      if (prdata[7] === 1'b1) break;
    end
    // wvalid-check negedge falls in the first WAIT cycle; flag shows after TO_CYC WAIT cycles
    check("timeout_latency", 32'(n), 32'(TO_CYC));
    check("timeout_status", prdata, 32'h0000_008C);
    psel = 1'b0; penable = 1'b0;
    apb_write(32'h0C, 32'h80, err);
    check_status("timeout_cleared", 32'h0000_000C);

    // Read FIFO overflow after 5 reads
    for (int i = 0; i < 5; i++) begin
      push_cmd(32'h0200_0000 | (32'(i) << 8));
      wait_wvalid();
      master_resp(3, 1'b1, 8'hC0 + 8'(i), 1'b0);
    end
    check_status("rd_ovf_status", 32'h0000_0054);
    for (int i = 0; i < 4; i++) begin
      apb_read(32'h08, d, err);
      check("rd_drain", d, {23'd0, 1'b1, rd_q.pop_front()});
    end
    apb_read(32'h08, d, err);
    check("rd_drain_empty", d, 32'd0);

    // Illegal accesses
    apb_read(32'h14, d, err);
    check("bad_addr_rd_slverr", 32'(err), 32'd1);
    check("bad_addr_rd_data", d, 32'd0);
    apb_write(32'h14, 32'hFFFF_FFFF, err);
    check("bad_addr_wr_slverr", 32'(err), 32'd1);
    apb_read(32'h04, d, err);
    check("cmd_read_slverr", 32'(err), 32'd1);
    apb_write(32'h08, 32'h1, err);
    check("rdata_write_slverr", 32'(err), 32'd1);
    check_status("no_side_effect", 32'h0000_004C);

    // Asynchronous reset mid-WAIT
    push_cmd(32'h0100_99EE);
    wait_wvalid();
    repeat (5) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("arst_addr", 32'(i2c_addr), 32'd0);
    check("arst_wdata", 32'(i2c_wdata), 32'd0);
    check("arst_bit_ctrl", 32'(bit_ctrl), 32'd0);
    check("arst_wvalid", 32'(wvalid), 32'd0);
    @(negedge clk) rstn = 1'b1;
    check_status("arst_status", 32'h0000_000C);
    apb_read(32'h00, d, err);
    check("arst_ctrl", d, 32'd0);
    check("scoreboard_drained", 32'(cmd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/i2c_master_apb_csr.md
Name: i2c_master_apb_csr

Overview:
- APB3 slave register file and command sequencer that sits directly upstream of i2c_master_module and drives its command interface.
- Software pushes I2C byte commands into a command FIFO. The sequencer issues them one at a time, waits for completion, and collects read bytes into a read-data FIFO.
- Sticky NACK, timeout and overflow flags are exposed for polling.

Parameters:
- APB_ABIT, 32, APB address width.
- APB_DBIT, 32, APB data width; fixed at 32.
- CMD_DEPTH, 4, command FIFO depth; power of 2, at least 2.
- RD_DEPTH, 4, read-data FIFO depth; power of 2, at least 2.
- TIMEOUT_CYC, 200000, apb_clk cycles allowed from issue to i_i2c_done.
- HALT_ON_NACK, 1, when 1 no further commands issue while the NACK flag is set.

Ports:
- apb_clk  in  1  clock.
- apb_rstn  in  1  asynchronous active-low reset.
- i_apb_psel  in  1  APB select.
- i_apb_penable  in  1  APB enable.
- i_apb_pwrite  in  1  1 = write.
- i_apb_paddr  in  APB_ABIT  byte address; bits [4:2] decoded.
- i_apb_pwdata  in  32  write data.
- i_apb_prot  in  3  ignored.
- i_apb_pstrb  in  4  ignored; all writes are full-word.
- o_apb_pready  out  1  tied 1 (zero wait state).
- o_apb_prdata  out  32  read data; valid in access phase, 0 otherwise.
- o_apb_slverr  out  1  error; access phase only.
- o_i2c_wvalid  out  1  one-cycle command start pulse to the master.
- o_cmd_bit_ctrl  out  1  1 = 16-bit word address, 0 = 8-bit.
- o_cmd_rh_wl  out  1  1 = read, 0 = write.
- o_i2c_addr  out  16  word address.
- o_i2c_wdata  out  8  write byte.
- i_i2c_rdata  in  8  read byte.
- i_i2c_rvalid  in  1  read byte valid pulse.
- i_i2c_done  in  1  transaction complete pulse.
- i_i2c_ack  in  1  1 = slave NACKed during the transaction.
- i_i2c_busy  in  1  master busy (status only).

Behaviour:
- Reset: every output is 0 except o_apb_pready = 1. Both FIFOs are empty, all flags are clear, CTRL.enable = 0 and the FSM is in IDLE.
- An access is psel & penable; all side effects take place in that cycle only.

Register map:
- 0x00 CTRL, RW.
  - [0] enable.
  - [1] flush: write-1 self-clears and empties both FIFOs in the same cycle; reads as 0.
- 0x04 CMD, WO.
  - Fields: [7:0] wdata, [23:8] addr, [24] bit_ctrl, [25] rh_wl.
  - A write pushes the command FIFO.
  - If the FIFO is full before this cycle's pop, the write is dropped and slverr = 1 (no simultaneous-pop rescue).
  - A read returns 0 with slverr = 1.
- 0x08 RDATA, RO.
  - Returns {23'b0, valid, byte}.
  - If the FIFO is non-empty it returns the head with valid = 1 and pops it.
  - If empty it returns 0 with no pop.
  - A write gives slverr = 1.
- 0x0C STATUS.
  - [0] busy = FSM != IDLE | cmd non-empty.
  - [1] cmd_full, [2] cmd_empty, [3] rd_empty, [4] rd_full.
  - [5] nack, [6] rd_ovf, [7] timeout.
  - [15:8] cmd count.
  - [5] to [7] are sticky and W1C.
  - i_i2c_busy is not a STATUS bit.
- Any other address: slverr = 1, prdata = 0, no side effect.

FSM (IDLE, ISSUE, WAIT):
- IDLE to ISSUE when enable & cmd non-empty & !(HALT_ON_NACK & nack).
- ISSUE:
  - Present the head on the o_cmd/o_i2c fields, assert o_i2c_wvalid for exactly 1 cycle and pop the FIFO.
  - The fields hold their value until the next ISSUE.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - On i_i2c_rvalid with a read command, push i_i2c_rdata. If rd is full, drop the byte and set rd_ovf.
  - On i_i2c_done, go to IDLE and set nack if i_i2c_ack = 1.
  - If rvalid and done coincide, both take effect.
  - When the counter reaches TIMEOUT_CYC - 1 without done, set timeout and go to IDLE.
- ISSUE-to-ISSUE spacing is therefore at least 3 cycles.

Boundary rules:
- Clearing enable mid-WAIT: the current transaction completes; nothing further issues.
- Flush mid-WAIT: the FSM is unaffected, and a later read byte is still pushed.
- Flush in the same cycle as a CMD write: flush wins and the push is lost.
- Same-cycle push and pop of the rd FIFO are both honoured.
- W1C in the same cycle as a set event: the set wins.
- Asynchronous reset mid-transaction returns everything to reset state immediately. The master is not aborted.

Decomposition:
- Package i2c_apb_pkg:
  - Register offsets (CTRL/CMD/RDATA/STATUS).
  - CMD and STATUS bit-field indices.
  - FSM state encoding.
  - Command entry width (26).
- Sub-module i2c_sync_fifo (WIDTH, DEPTH) provides synchronous push/pop/flush, full, empty and count. It is instantiated twice: 26-bit command, 8-bit read.

Test Plan:
- Set enable = 1, write CMD 0x0000_12AB (8-bit write, addr 0x0012, data 0xAB), then respond with done after 50 cycles and ack = 0 → one wvalid pulse with addr = 0x0012, wdata = 0xAB, rh_wl = 0, bit_ctrl = 0; STATUS.busy = 0 afterwards and nack = 0.
- Write CMD 0x0300_3400 (16-bit read, addr 0x0034), then have the master return rvalid with 0x5A followed by done → RDATA reads 0x0000_015A, and a second RDATA read returns 0x0000_0000.
- With enable = 0, write CMD 5 times at CMD_DEPTH = 4 → the 5th write gives slverr = 1, STATUS[1] = 1 and count = 4; no wvalid pulse.
- Drive i_i2c_ack = 1 on done with 2 commands queued and HALT_ON_NACK = 1 → nack = 1 and the second command does not issue; W1C 0x20 to STATUS clears nack and the second command issues.
- Never assert done → timeout is set exactly TIMEOUT_CYC cycles after the ISSUE state and the FSM returns to IDLE; 5 completed reads without draining RDATA set rd_ovf with the FIFO holding the first 4 bytes.
- Access at 0x14 gives slverr = 1 with prdata = 0; assert apb_rstn = 0 mid-WAIT → all outputs return to reset values asynchronously.
